// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-mapped I/O responder on the processor's external memory bus.
//   It claims the window IOBASE..IOBASE+3 plus HALTADDR, pushes TXDATA stores
//   into a small transmit FIFO drained by a valid/ready consumer, and raises a
//   sticky halt flag on a store to HALTADDR.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   memread    in   1      processor read strobe
//   memwrite   in   1      processor write strobe
//   mar        in   WIDTH  processor address
//   writedata  in   WIDTH  processor store data
//   iosel      out  1      mar hits the window or HALTADDR (combinational)
//   iodata     out  WIDTH  read data, 0 when not selected (combinational)
//   out_valid  out  1      FIFO non-empty
//   out_data   out  WIDTH  FIFO head; holds the last popped value when empty
//   out_ready  in   1      consumer accepts the head entry
//   kraj       out  1      sticky halt flag
//   haltcode   out  WIDTH  value stored to HALTADDR
//
// Handshake: an entry leaves the FIFO on every rising edge where
// out_valid & out_ready; out_valid never depends on out_ready.
//
// STATUS layout: bit0 empty, bit1 full, bit2 ovf, bit3 kraj,
// bits[7:4] occupancy, higher bits 0.
module mmio_responder #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] IOBASE   = 8'hF8,
    parameter logic [WIDTH-1:0] HALTADDR = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] mar,
    input  logic [WIDTH-1:0] writedata,
    output logic             iosel,
    output logic [WIDTH-1:0] iodata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             kraj,
    output logic [WIDTH-1:0] haltcode
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    occ;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] tx_count;
    logic [WIDTH-1:0] haltcode_q;
    logic             ovf;
    logic             kraj_q;

    // Address decode: the window is four registers starting at IOBASE.
    logic [WIDTH-1:0] offset;
    logic             in_win, is_halt;
    logic             sel_tx, sel_status, sel_count, sel_clr;

    assign offset     = mar - IOBASE;
    assign in_win     = (offset[WIDTH-1:2] == '0);
    assign is_halt    = (mar == HALTADDR);
    assign sel_tx     = in_win && (offset[1:0] == 2'd0);
    assign sel_status = in_win && (offset[1:0] == 2'd1);
    assign sel_count  = in_win && (offset[1:0] == 2'd2);
    assign sel_clr    = in_win && (offset[1:0] == 2'd3);
    assign iosel      = in_win || is_halt;

    logic empty, full, pop, wr_take, push_req, push, ovf_set, clr;

    assign empty    = (occ == '0);
    assign full     = (occ == CW'(DEPTH));
    assign pop      = !empty && out_ready;
    // Once halted the responder ignores every store, halt stores included.
    assign wr_take  = memwrite && iosel && !kraj_q;
    assign push_req = wr_take && sel_tx;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign clr      = memread && sel_clr;

    logic [WIDTH-1:0] status;

    always_comb begin
        status      = '0;
        status[0]   = empty;
        status[1]   = full;
        status[2]   = ovf;
        status[3]   = kraj_q;
        status[7:4] = 4'(occ);
    end

    always_comb begin
        iodata = '0;
        if (sel_status || sel_clr) iodata = status;
        else if (sel_count)        iodata = tx_count;
        else if (is_halt)          iodata = haltcode_q;
    end

    assign out_valid = !empty;
    // last_q keeps the most recently popped entry visible once the FIFO empties.
    assign out_data  = empty ? last_q : mem[rd_ptr];
    assign kraj      = kraj_q;
    assign haltcode  = haltcode_q;

    // Storage needs no reset: an empty FIFO shows last_q, never mem.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            last_q     <= '0;
            tx_count   <= '0;
            ovf        <= 1'b0;
            kraj_q     <= 1'b0;
            haltcode_q <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                tx_count <= tx_count + WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            // A fresh overflow in the same cycle as a CLR read wins.
            if (ovf_set)  ovf <= 1'b1;
            else if (clr) ovf <= 1'b0;
            if (wr_take && is_halt) begin
                kraj_q     <= 1'b1;
                haltcode_q <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] mar = '0;
  logic [7:0] writedata = '0;
  logic       out_ready = 1'b0;
  logic       iosel;
  logic [7:0] iodata;
  logic       out_valid;
  logic [7:0] out_data;
  logic       kraj;
  logic [7:0] haltcode;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mmio_responder #(.WIDTH(8), .DEPTH(4), .IOBASE(8'hF8), .HALTADDR(8'hFF)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .mar(mar), .writedata(writedata), .iosel(iosel), .iodata(iodata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .kraj(kraj), .haltcode(haltcode)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // The transmit FIFO is a plain queue; registers are plain variables
  // holding their post-edge values.
  logic [7:0] m_q[$];
  logic       m_ovf, m_kraj;
  logic [7:0] m_count, m_halt, m_last;
  logic [7:0] dut_pops[$];

  function automatic logic [7:0] m_status();
    return {4'(m_q.size()), m_kraj, m_ovf, (m_q.size() == 4), (m_q.size() == 0)};
  endfunction

  function automatic void m_clear();
    m_q.delete();
    m_ovf = 0; m_kraj = 0; m_count = 0; m_halt = 0; m_last = 0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model for the inputs currently applied.
  task automatic model_check();
    logic [7:0] e_io;
    logic       e_sel;
    e_sel = (mar >= 8'hF8 && mar <= 8'hFB) || (mar == 8'hFF);
    case (mar)
      8'hF9, 8'hFB: e_io = m_status();
      8'hFA:        e_io = m_count;
      8'hFF:        e_io = m_halt;
      default:      e_io = 8'h00;
    endcase
    chk("iosel", {7'd0, iosel}, {7'd0, e_sel});
    chk("iodata", iodata, e_io);
    chk("out_valid", {7'd0, out_valid}, {7'd0, (m_q.size() != 0)});
    chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : m_last);
    chk("kraj", {7'd0, kraj}, {7'd0, m_kraj});
    chk("haltcode", haltcode, m_halt);
    if (out_valid && out_ready) dut_pops.push_back(out_data);
  endtask

  // Advance the model over the coming rising edge.
  task automatic model_step();
    int  pre;
    bit  sel, take, pop;
    pre  = m_q.size();
    sel  = (mar >= 8'hF8 && mar <= 8'hFB) || (mar == 8'hFF);
    take = memwrite && sel && !m_kraj;
    pop  = (pre > 0) && out_ready;
    if (memread && mar == 8'hFB) m_ovf = 0;
    if (pop) m_last = m_q.pop_front();
    if (take && mar == 8'hF8) begin
      if (pre < 4 || pop) begin
        m_q.push_back(writedata);
        m_count = m_count + 8'd1;
      end else begin
        m_ovf = 1;
      end
    end
    if (take && mar == 8'hFF) begin
      m_kraj = 1;
      m_halt = writedata;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit mr, input bit mw, input logic [7:0] addr,
                       input logic [7:0] wd, input bit rdy);
    @(negedge clk);
    memread = mr; memwrite = mw; mar = addr; writedata = wd; out_ready = rdy;
    #1;
  endtask

  task automatic cyc(input bit mr, input bit mw, input logic [7:0] addr,
                     input logic [7:0] wd, input bit rdy);
    drive(mr, mw, addr, wd, rdy);
    model_check();
    model_step();
  endtask

  // Reset is applied mid-cycle; its effect must be visible with no clock edge.
  task automatic do_reset();
    @(negedge clk);
    memwrite = 0; memread = 1; mar = 8'hF9; writedata = 0; out_ready = 0;
    #1;
    reset = 0;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_status", iodata, 8'h01);
    chk("rst_kraj", {7'd0, kraj}, 8'h00);
    chk("rst_haltcode", haltcode, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    m_clear();
    #1;
    reset = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    bit         mr;
    bit         mw;
    logic [7:0] addr;
    logic [7:0] wd;
    bit         rdy;
    logic [7:0] e_io;
    bit         e_sel;
    bit         e_valid;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(bit rst, bit mr, bit mw, logic [7:0] addr, logic [7:0] wd,
                              bit rdy, logic [7:0] e_io, bit e_sel, bit e_valid,
                              logic [7:0] e_data);
    vec_t v;
    v.rst = rst; v.mr = mr; v.mw = mw; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.e_io = e_io; v.e_sel = e_sel; v.e_valid = e_valid; v.e_data = e_data;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // basic push / status / drain
    tbl.push_back(mk(1, 0, 1, 8'hF8, 8'h11, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'hF8, 8'h22, 0, 8'h00, 1, 1, 8'h11));
    tbl.push_back(mk(0, 0, 1, 8'hF8, 8'h33, 0, 8'h00, 1, 1, 8'h11));
    tbl.push_back(mk(0, 1, 0, 8'hF9, 8'h00, 0, 8'h30, 1, 1, 8'h11));
    tbl.push_back(mk(0, 1, 0, 8'hFA, 8'h00, 0, 8'h03, 1, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1, 8'h33));
    tbl.push_back(mk(0, 1, 0, 8'hF9, 8'h00, 1, 8'h01, 1, 0, 8'h33));
    // overflow and CLR
    tbl.push_back(mk(1, 0, 1, 8'hF8, 8'hA0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'hF8, 8'hA1, 0, 8'h00, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 0, 1, 8'hF8, 8'hA2, 0, 8'h00, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 0, 1, 8'hF8, 8'hA3, 0, 8'h00, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 0, 1, 8'hF8, 8'hA4, 0, 8'h00, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'hF9, 8'h00, 0, 8'h46, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'hFA, 8'h00, 0, 8'h04, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'hFB, 8'h00, 0, 8'h46, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'hF9, 8'h00, 0, 8'h42, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'hF8, 8'h00, 0, 8'h00, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'hFF, 8'h00, 0, 8'h00, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 1, 8'hA0));
  end

  // ---------------- test sequence ----------------
  initial begin
    m_clear();
    #2;

    // Table-driven vectors
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].mr, tbl[i].mw, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
      chk($sformatf("vec%0d_iodata", i), iodata, tbl[i].e_io);
      chk($sformatf("vec%0d_iosel", i), {7'd0, iosel}, {7'd0, tbl[i].e_sel});
      chk($sformatf("vec%0d_valid", i), {7'd0, out_valid}, {7'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
      model_step();
    end

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hF8, 8'hC0 + 8'(i), 0);
    dut_pops.delete();
    cyc(0, 1, 8'hF8, 8'h55, 1);
    cyc(1, 0, 8'hF9, 8'h00, 0);
    chk("full_pushpop_status", iodata, 8'h42);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 8'h00, 1);
    chk("full_pushpop_npops", 8'(dut_pops.size()), 8'd5);
    if (dut_pops.size() > 0) chk("full_pushpop_last", dut_pops[dut_pops.size() - 1], 8'h55);

    // Halt behaviour
    do_reset();
    cyc(0, 1, 8'hFF, 8'h07, 0);
    cyc(1, 0, 8'hFF, 8'h00, 0);
    chk("halt_kraj", {7'd0, kraj}, 8'h01);
    chk("halt_code_read", iodata, 8'h07);
    cyc(0, 1, 8'hF8, 8'h99, 0);
    cyc(0, 1, 8'hFF, 8'h08, 0);
    cyc(1, 0, 8'hFA, 8'h00, 0);
    chk("halt_count_frozen", iodata, 8'h00);
    cyc(1, 1, 8'hFF, 8'h09, 0);
    chk("halt_code_held", haltcode, 8'h07);

    // 256 pushes with the consumer always ready: COUNT wraps, order preserved
    do_reset();
    dut_pops.delete();
    for (int i = 0; i < 256; i++) cyc(0, 1, 8'hF8, 8'(i), 1);
    cyc(1, 0, 8'hFA, 8'h00, 1);
    chk("wrap_count", iodata, 8'h00);
    cyc(0, 0, 8'h00, 8'h00, 1);
    chk("wrap_npops", 8'(dut_pops.size() == 256), 8'd1);
    for (int i = 0; i < dut_pops.size() && i < 256; i++)
      if (dut_pops[i] !== 8'(i)) chk($sformatf("wrap_order%0d", i), dut_pops[i], 8'(i));
    chk("wrap_order", 8'(dut_pops.size() > 255 ? dut_pops[255] : 8'h00), 8'hFF);

    // Read and write together: iodata shows the pre-edge value
    do_reset();
    cyc(1, 1, 8'hF8, 8'h3C, 0);
    cyc(1, 0, 8'hF9, 8'h00, 0);
    chk("rw_status_after", iodata, 8'h10);

    // Asynchronous reset mid-stream, with kraj set
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'hF8, 8'h60 + 8'(i), 0);
    cyc(0, 1, 8'hFF, 8'h5A, 0);
    cyc(1, 0, 8'hF9, 8'h00, 0);
    chk("midrst_pre_status", iodata, 8'h38);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      int         sel;
      logic [7:0] a;
      if (n % 500 == 499) do_reset();
      sel = $urandom_range(0, 39);
      if (sel < 16)      a = 8'hF8;
      else if (sel < 24) a = 8'hF9;
      else if (sel < 28) a = 8'hFA;
      else if (sel < 32) a = 8'hFB;
      else if (sel < 33) a = 8'hFF;
      else               a = 8'($urandom_range(0, 255));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
          8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
